// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: opcodes, control
// encodings, FSM states and the coarse instruction classification.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE   = 3'd0,
    C_IALU    = 3'd1,
    C_LOAD    = 3'd2,
    C_STORE   = 3'd3,
    C_BRANCH  = 3'd4,
    C_ILLEGAL = 3'd5
  } instr_class_t;

  // Everything the controller drives into the DataPath and memories in one cycle.
  typedef struct packed {
    logic       imemReq;
    logic       irWrite;
    logic       dmemReq;
    logic       dmemWe;
    logic       branch;
    logic       jump;
    logic       regWrite;
    logic       aluSrc;
    logic [1:0] inmSrc;
    logic [1:0] resultSrc;
    logic [2:0] aluControl;
  } ctrl_t;

  function automatic instr_class_t classify(input logic [6:0] op);
    case (op)
      OP_RTYPE:  return C_RTYPE;
      OP_IALU:   return C_IALU;
      OP_LOAD:   return C_LOAD;
      OP_STORE:  return C_STORE;
      OP_BRANCH: return C_BRANCH;
      default:   return C_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational op/funct3/funct7 to ALU operation decode; shared with the
// single-cycle control path.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] f3_i,
  input  logic       f7_i,
  output logic [2:0] aluControl_o
);

  logic [2:0] funcAlu;

  always_comb begin
    case (f3_i)
      F3_ADD:  funcAlu = ALU_ADD;
      F3_SLT:  funcAlu = ALU_SLT;
      F3_OR:   funcAlu = ALU_OR;
      F3_AND:  funcAlu = ALU_AND;
      default: funcAlu = ALU_ADD;
    endcase
  end

  // SUB only exists for register-register ops; addi ignores the funct7 bit.
  always_comb begin
    aluControl_o = ALU_ADD;
    case (op_i)
      OP_RTYPE:  aluControl_o = (f3_i == F3_ADD && f7_i) ? ALU_SUB : funcAlu;
      OP_IALU:   aluControl_o = funcAlu;
      OP_BRANCH: aluControl_o = ALU_CMP;
      default:   aluControl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I DataPath: sequences fetch, decode,
// execute and memory phases against variable-latency memories and counts retirements.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic [2:0]  f3,
  input  logic        f7,
  input  logic        zero,
  input  logic        imemReady,
  input  logic        dmemReady,
  output logic        imemReq,
  output logic        irWrite,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic        branch,
  output logic        jump,
  output logic        regWrite,
  output logic        aluSrc,
  output logic [1:0]  inmSrc,
  output logic [1:0]  resultSrc,
  output logic [2:0]  aluControl,
  output logic        illegal,
  output logic [31:0] retired
);

  state_t       state_q;
  instr_class_t class_q;
  logic         illegal_q;
  logic [31:0]  retired_q;
  logic [31:0]  retired_d;

  instr_class_t decClass;
  logic [2:0]   decAluControl;
  ctrl_t        ctrl;

  // The branch decision happens in the DataPath; zero is only passed through the interface.
  logic unusedZero;
  assign unusedZero = zero;

  assign decClass  = classify(op);
  assign retired_d = retired_q + 32'd1;

  alu_decoder u_alu_decoder (
    .op_i        (op),
    .f3_i        (f3),
    .f7_i        (f7),
    .aluControl_o(decAluControl)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      class_q   <= C_ILLEGAL;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (ctrl.jump) retired_q <= retired_d;
      case (state_q)
        S_FETCH: if (imemReady) state_q <= S_DECODE;
        S_DECODE: begin
          class_q <= decClass;
          if (decClass == C_ILLEGAL) begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC:  state_q <= (class_q == C_LOAD || class_q == C_STORE) ? S_MEM : S_FETCH;
        S_MEM:   if (dmemReady) state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Outputs decode the registered state; holding rst_n low silences them in the same cycle.
  always_comb begin
    ctrl = '0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          ctrl.imemReq = 1'b1;
          ctrl.irWrite = imemReady;
        end
        S_EXEC: begin
          ctrl.aluControl = decAluControl;
          case (class_q)
            C_RTYPE: begin
              ctrl.regWrite  = 1'b1;
              ctrl.resultSrc = RES_ALU;
              ctrl.jump      = 1'b1;
            end
            C_IALU: begin
              ctrl.regWrite  = 1'b1;
              ctrl.resultSrc = RES_ALU;
              ctrl.aluSrc    = 1'b1;
              ctrl.inmSrc    = IMM_I;
              ctrl.jump      = 1'b1;
            end
            C_BRANCH: begin
              ctrl.branch = 1'b1;
              ctrl.inmSrc = IMM_B;
              ctrl.jump   = 1'b1;
            end
            C_LOAD: begin
              ctrl.aluSrc = 1'b1;
              ctrl.inmSrc = IMM_I;
            end
            C_STORE: begin
              ctrl.aluSrc = 1'b1;
              ctrl.inmSrc = IMM_S;
            end
            default: ctrl.aluControl = ALU_ADD;
          endcase
        end
        S_MEM: begin
          ctrl.dmemReq    = 1'b1;
          ctrl.dmemWe     = (class_q == C_STORE);
          ctrl.aluSrc     = 1'b1;
          ctrl.inmSrc     = (class_q == C_STORE) ? IMM_S : IMM_I;
          ctrl.aluControl = decAluControl;
          if (dmemReady) begin
            ctrl.jump = 1'b1;
            if (class_q == C_LOAD) begin
              ctrl.regWrite  = 1'b1;
              ctrl.resultSrc = RES_MEM;
            end
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign imemReq    = ctrl.imemReq;
  assign irWrite    = ctrl.irWrite;
  assign dmemReq    = ctrl.dmemReq;
  assign dmemWe     = ctrl.dmemWe;
  assign branch     = ctrl.branch;
  assign jump       = ctrl.jump;
  assign regWrite   = ctrl.regWrite;
  assign aluSrc     = ctrl.aluSrc;
  assign inmSrc     = ctrl.inmSrc;
  assign resultSrc  = ctrl.resultSrc;
  assign aluControl = ctrl.aluControl;
  assign illegal    = illegal_q & rst_n;
  assign retired    = retired_q;

  // Handshake invariants that must hold whenever the controller is out of reset.
  irWriteNeedsFetch: assert property (@(posedge clk) disable iff (!rst_n) irWrite |-> imemReq);
  writeNeedsRequest: assert property (@(posedge clk) disable iff (!rst_n) dmemWe |-> dmemReq);
  jumpOnlyAtRetire:  assert property (@(posedge clk) disable iff (!rst_n)
                                      jump |-> (state_q == S_EXEC || state_q == S_MEM));
  haltIsQuiet:       assert property (@(posedge clk) disable iff (!rst_n)
                                      illegal |-> !(imemReq || jump || dmemReq));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: randomized instruction stream with
// variable memory latency, checked by a scoreboard fed from a per-instruction model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        f7;
  logic        zero;
  logic        imemReady;
  logic        dmemReady;
  logic        imemReq;
  logic        irWrite;
  logic        dmemReq;
  logic        dmemWe;
  logic        branch;
  logic        jump;
  logic        regWrite;
  logic        aluSrc;
  logic [1:0]  inmSrc;
  logic [1:0]  resultSrc;
  logic [2:0]  aluControl;
  logic        illegal;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int issued = 0;
  int imemCnt = 0;
  int dmemCnt = 0;
  int irCnt   = 0;

  typedef struct {
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       branch;
    logic       aluSrc;
    logic [1:0] inmSrc;
    logic [2:0] aluControl;
    logic       memOp;
    logic       dmemWe;
    int         retireCycle;
    int         retiredBefore;
    int         fetchCycles;
    int         memCycles;
  } exp_t;

  exp_t sb[$];
  exp_t monE;

  logic [6:0] opTab [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
  logic [2:0] f3Tab [4] = '{3'b000, 3'b111, 3'b110, 3'b010};

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .f3        (f3),
    .f7        (f7),
    .zero      (zero),
    .imemReady (imemReady),
    .dmemReady (dmemReady),
    .imemReq   (imemReq),
    .irWrite   (irWrite),
    .dmemReq   (dmemReq),
    .dmemWe    (dmemWe),
    .branch    (branch),
    .jump      (jump),
    .regWrite  (regWrite),
    .aluSrc    (aluSrc),
    .inmSrc    (inmSrc),
    .resultSrc (resultSrc),
    .aluControl(aluControl),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // ALU operation named by the instruction table: add/sub/and/or/slt.
  function automatic logic [2:0] ruleAlu(input logic [2:0] fn3, input logic isReg, input logic bit30);
    case (fn3)
      3'b000:  return (isReg && bit30) ? 3'b001 : 3'b000;
      3'b111:  return 3'b010;
      3'b110:  return 3'b011;
      3'b010:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // What the controller must show at the retirement of one instruction.
  task automatic refModel(input logic [6:0] iop, input logic [2:0] if3, input logic if7,
                          output exp_t e, output bit legal);
    e.regWrite = 1'b0; e.resultSrc = 2'b00; e.branch = 1'b0; e.aluSrc = 1'b0;
    e.inmSrc = 2'b00; e.aluControl = 3'b000; e.memOp = 1'b0; e.dmemWe = 1'b0;
    e.retireCycle = 0; e.retiredBefore = 0; e.fetchCycles = 0; e.memCycles = 0;
    legal = 1'b1;
    case (iop)
      7'b0110011: begin e.regWrite = 1'b1; e.aluControl = ruleAlu(if3, 1'b1, if7); end
      7'b0010011: begin e.regWrite = 1'b1; e.aluSrc = 1'b1; e.aluControl = ruleAlu(if3, 1'b0, if7); end
      7'b1100011: begin e.branch = 1'b1; e.inmSrc = 2'b10; e.aluControl = 3'b100; end
      7'b0000011: begin e.regWrite = 1'b1; e.resultSrc = 2'b01; e.aluSrc = 1'b1; e.memOp = 1'b1; end
      7'b0100011: begin e.aluSrc = 1'b1; e.inmSrc = 2'b01; e.memOp = 1'b1; e.dmemWe = 1'b1; end
      default:    legal = 1'b0;
    endcase
  endtask

  // Plays the memories and instruction register for one instruction; starts and ends in FETCH.
  task automatic applyStimulus(input logic [6:0] iop, input logic [2:0] if3, input logic if7,
                               input logic izero, input int iWait, input int dWait);
    exp_t e;
    bit   legal;
    int   lat;
    refModel(iop, if3, if7, e, legal);
    lat = e.memOp ? (4 + iWait + dWait) : (3 + iWait);
    e.retireCycle   = cycle + lat - 1;
    e.retiredBefore = issued;
    e.fetchCycles   = iWait + 1;
    e.memCycles     = e.memOp ? dWait + 1 : 0;
    if (legal) begin
      sb.push_back(e);
      issued++;
    end
    for (int k = 0; k <= iWait; k++) begin
      imemReady = (k == iWait);
      dmemReady = 1'($urandom);
      @(posedge clk); #1;
    end
    op = iop; f3 = if3; f7 = if7; zero = izero;
    imemReady = 1'($urandom);
    dmemReady = 1'($urandom);
    @(posedge clk); #1;
    if (!legal) begin
      imemReady = 1'b0;
      dmemReady = 1'b0;
      return;
    end
    imemReady = 1'($urandom);
    dmemReady = 1'($urandom);
    @(posedge clk); #1;
    if (e.memOp) begin
      for (int k = 0; k <= dWait; k++) begin
        dmemReady = (k == dWait);
        imemReady = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    imemReady = 1'b0;
    dmemReady = 1'b0;
  endtask

  task automatic doReset(input int n);
    rst_n = 1'b0;
    imemReady = 1'b0;
    dmemReady = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    issued = 0;
    rst_n = 1'b1;
    #1;
    checkOutput("imemReqAfterRelease", 32'(imemReq), 32'd1);
  endtask

  // Monitor: pops the scoreboard on every jump pulse and compares the retiring controls.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("resetQuiet", 32'({imemReq, irWrite, dmemReq, dmemWe, jump, regWrite, branch, illegal}), 32'd0);
      imemCnt = 0; dmemCnt = 0; irCnt = 0;
    end else begin
      if (imemReq) imemCnt++;
      if (dmemReq) dmemCnt++;
      if (irWrite) irCnt++;
      if (jump) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedJump: got jump=1, expected 0 (no instruction outstanding, cycle %0d)", cycle);
        end else begin
          monE = sb.pop_front();
          checkOutput("retireCycle", cycle, monE.retireCycle);
          checkOutput("retiredBefore", retired, monE.retiredBefore);
          checkOutput("regWrite", 32'(regWrite), 32'(monE.regWrite));
          checkOutput("resultSrc", 32'(resultSrc), 32'(monE.resultSrc));
          checkOutput("branch", 32'(branch), 32'(monE.branch));
          checkOutput("aluSrc", 32'(aluSrc), 32'(monE.aluSrc));
          checkOutput("inmSrc", 32'(inmSrc), 32'(monE.inmSrc));
          checkOutput("aluControl", 32'(aluControl), 32'(monE.aluControl));
          checkOutput("dmemReqAtRetire", 32'(dmemReq), 32'(monE.memOp));
          checkOutput("dmemWe", 32'(dmemWe), 32'(monE.dmemWe));
          checkOutput("fetchCycles", imemCnt, monE.fetchCycles);
          checkOutput("memCycles", dmemCnt, monE.memCycles);
          checkOutput("irWritePulses", irCnt, 32'd1);
        end
        imemCnt = 0; dmemCnt = 0; irCnt = 0;
      end else begin
        checkOutput("quietWithoutJump", 32'({regWrite, branch}), 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; op = '0; f3 = '0; f7 = 1'b0; zero = 1'b0;
    imemReady = 1'b0; dmemReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetRetired", retired, 32'd0);
    checkOutput("resetIllegal", 32'(illegal), 32'd0);
    checkOutput("resetImemReq", 32'(imemReq), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("imemReqAfterRelease", 32'(imemReq), 32'd1);

    applyStimulus(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0);
    checkOutput("retiredAfterAddi", retired, 32'd1);
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
    checkOutput("retiredAfterBeq", retired, 32'd2);
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
    checkOutput("retiredAfterLw", retired, 32'd3);
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0);
    checkOutput("retiredAfterSw", retired, 32'd4);
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b1, 1, 0);

    for (int n = 0; n < 80; n++) begin
      int kind;
      logic [2:0] rf3;
      kind = int'($urandom_range(0, 4));
      rf3 = (kind < 2) ? f3Tab[$urandom_range(0, 3)] : 3'($urandom);
      applyStimulus(opTab[kind], rf3, 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    applyStimulus(7'h7F, 3'b000, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      imemReady = 1'b1;
      dmemReady = 1'b1;
      @(negedge clk);
      checkOutput("haltImemReq", 32'(imemReq), 32'd0);
      checkOutput("haltIllegal", 32'(illegal), 32'd1);
      checkOutput("haltRetired", retired, 32'(issued));
      @(posedge clk); #1;
    end

    doReset(2);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(opTab[n], 3'b000, 1'b0, 1'b0, 0, 1);
    end

    imemReady = 1'b1;
    @(posedge clk); #1;
    op = 7'b0000011; f3 = 3'b010; imemReady = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dmemReady = 1'b0;
    @(negedge clk);
    checkOutput("memWaitReq", 32'(dmemReq), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    dmemReady = 1'b1;
    #1;
    checkOutput("resetDropsReq", 32'(dmemReq), 32'd0);
    checkOutput("resetNoJump", 32'({jump, regWrite}), 32'd0);
    @(posedge clk); #1;
    issued = 0;
    dmemReady = 1'b0;
    checkOutput("retiredClearedByReset", retired, 32'd0);
    checkOutput("imemReqHeldInReset", 32'(imemReq), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkOutput("imemReqAfterMemReset", 32'(imemReq), 32'd1);
    applyStimulus(7'b0010011, 3'b111, 1'b0, 1'b0, 0, 0);
    checkOutput("retiredAfterRecovery", retired, 32'd1);

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk);
    checkOutput("scoreboardDrained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM that sequences the RV32I DataPath against instruction and data memories with variable latency. It fetches each instruction and holds it in the DataPath's instruction register. It decodes op/f3/f7 into DataPath control, waits on memory handshakes, and enables register writeback and the PC update in exactly one cycle per instruction. It sits between the top-level memories and DataPath and replaces the combinational control used in single-cycle benches.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- op  in  7  opcode from DataPath instruction register
- f3  in  3  funct3 from DataPath
- f7  in  1  funct7 bit 5 from DataPath
- zero  in  1  ALU zero flag from DataPath
- imemReady  in  1  instruction word valid this cycle
- dmemReady  in  1  data access complete this cycle
- imemReq  out  1  instruction fetch request
- irWrite  out  1  latch instruction word into DataPath
- dmemReq  out  1  data memory request
- dmemWe  out  1  data memory write (SW)
- branch  out  1  DataPath branch
- jump  out  1  DataPath PC-update enable
- regWrite  out  1  register file write enable
- aluSrc  out  1  0 = register, 1 = immediate
- inmSrc  out  2  00 I, 01 S, 10 B
- resultSrc  out  2  00 ALU, 01 memory, 10 PC+4
- aluControl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 CMP (sub, drives zero), 101 SLT
- illegal  out  1  sticky illegal-opcode flag
- retired  out  32  count of completed instructions

## Operation
- Supported opcodes:
  - R-type 0110011: add, sub, and, or, slt; f7 = 1 with f3 = 000 selects SUB.
  - I-ALU 0010011: addi, andi, ori, slti.
  - LW 0000011.
  - SW 0100011.
  - BEQ 1100011.
- Any other opcode is illegal.
- States: FETCH, DECODE, EXEC, MEM, HALT.
- FETCH:
  - imemReq = 1.
  - On imemReady, irWrite = 1 and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - One cycle; op/f3/f7 are stable.
  - Illegal opcode goes to HALT; otherwise go to EXEC.
- EXEC, R and I-ALU:
  - regWrite = 1, resultSrc = 00, jump = 1.
  - Go to FETCH.
- EXEC, BEQ:
  - branch = 1, inmSrc = 10, aluSrc = 0, aluControl = 100, jump = 1.
  - DataPath takes the target when zero = 1.
  - Go to FETCH.
- EXEC, LW/SW:
  - aluSrc = 1, aluControl = 000; inmSrc = 00 for LW, 01 for SW.
  - Go to MEM.
- MEM:
  - dmemReq = 1; dmemWe = 1 for SW.
  - Address and control are held constant while waiting.
  - On dmemReady: jump = 1; LW additionally asserts regWrite = 1 and resultSrc = 01 (readData is valid in the dmemReady cycle). Then go to FETCH.
- HALT: illegal = 1; all other outputs 0. Leaves only on reset.
- retired increments by 1 in every cycle where jump = 1. It wraps from 0xFFFFFFFF to 0.
- Outside the cycles listed above, all control outputs are 0 (regWrite, jump, branch, dmemReq, dmemWe, irWrite never glitch high).

## Timing
- Reset (rst_n = 0 at a clk edge):
  - state = FETCH, retired = 0, illegal = 0.
  - All outputs 0 except imemReq, which is 1 in the first cycle after reset release.
- Reset mid-operation (any state, including MEM while waiting): abort without regWrite or jump. Pending memory requests drop the same cycle.
- Latency with zero-wait memories (imemReady high in FETCH, dmemReady high in MEM):
  - R, I, BEQ: 3 cycles.
  - LW, SW: 4 cycles.
- Each memory wait cycle adds 1.
- All outputs are Moore/registered-state decodes, except irWrite and the MEM-exit signals, which are qualified by imemReady and dmemReady in the same cycle.
- imemReady or dmemReady asserted outside FETCH/MEM is ignored.
- Exactly one jump pulse per retired instruction.

## Structure
- Shared header `rv_defs.vh` holds:
  - opcode constants;
  - aluControl encodings;
  - inmSrc and resultSrc encodings;
  - state encodings.
- The ALU-control decode (op/f3/f7 to aluControl) goes in sub-module `alu_decoder`, which is combinational and reusable by single-cycle builds.
- The FSM and the retired counter stay in multicycle_ctrl.

## Test plan
- ADDI x2,x0,21 (op 0010011), zero-wait memories:
  - imemReq in cycle 0; irWrite in cycle 0; EXEC in cycle 2 with regWrite = 1, aluSrc = 1, aluControl = 000, jump = 1.
  - retired = 1.
- BEQ x0,x2,-36 with zero = 0:
  - EXEC: branch = 1, inmSrc = 10, aluControl = 100, jump = 1.
  - regWrite = 0; retired increments.
- LW with dmemReady held low 3 cycles:
  - Stays in MEM 4 cycles with dmemReq = 1, dmemWe = 0.
  - Final cycle: regWrite = 1, resultSrc = 01, jump = 1.
  - Total 7 cycles.
- SW, zero-wait:
  - MEM asserts dmemWe = 1, inmSrc = 01, regWrite = 0.
  - Instruction retires in 4 cycles.
- Opcode 0x7F: after DECODE enters HALT; illegal = 1; imemReq stays 0 for 10 cycles; retired unchanged.
- rst_n low during a MEM wait:
  - Next cycle: state FETCH, retired = 0, no regWrite or jump pulse.
  - After release, imemReq = 1.
